// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter: FSM encoding, default size, ID width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arbiter_pkg;

   // Two state bits; encoding 3 is unused and treated as IDLE by the arbiter.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_OWNED   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam int DEF_NUM_MASTERS = 2;

   // ID_W = max(1, clog2(n)).
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the master port blocks and the bus arbiter.
// Latency: n/a (wires only).
// Backpressure: req is a level held by the master until it no longer needs the bus.
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS
);
   localparam int ID_W = id_width(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] done;
   logic [NUM_MASTERS-1:0] grant;
   logic [ID_W-1:0]        grant_id;
   logic                   bus_busy;
   logic                   timeout;

   // Master side: drives requests and completion pulses, sees the grant.
   modport master (
      output req, done,
      input  grant, grant_id, bus_busy, timeout
   );

   // Arbiter side.
   modport slave (
      input  req, done,
      output grant, grant_id, bus_busy, timeout
   );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first set req bit searching upward from rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; winner is only meaningful while any_req is high.
module bus_arbiter_rr_picker
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int ID_W        = id_width(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [ID_W-1:0]        rr_ptr,
   output logic [ID_W-1:0]        winner,
   output logic                   any_req
);

   int idx;

   // Scan offsets from the far end down so the lowest offset from rr_ptr is the last write.
   always_comb begin
      winner  = '0;
      idx     = 0;
      any_req = |req;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % NUM_MASTERS;
         if (req[idx]) begin
            winner = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared serial bus, one idle turnaround cycle between owners.
// Latency: grant 1 cycle after req; release 1 cycle after done/req drop; 2 free cycles minimum between grants.
// Backpressure: owner holds the bus until done or req drop (or watchdog when ARB_TIMEOUT_EN is defined).
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic           clk,
   input  logic           reset,
   bus_arbiter_if.slave   bus
);

   localparam int ID_W = id_width(NUM_MASTERS);

   state_t                 state, state_next;
   logic [NUM_MASTERS-1:0] grant_r, grant_next;
   logic [ID_W-1:0]        grant_id_r, grant_id_next;
   logic [ID_W-1:0]        rr_ptr, rr_ptr_next;
   logic                   timeout_r, timeout_next;
   logic [ID_W-1:0]        winner;
   logic                   any_req;
   logic                   release_cond;
   logic                   wd_expire;

   bus_arbiter_rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .ID_W        (ID_W)
   ) u_picker (
      .req     (bus.req),
      .rr_ptr  (rr_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   // Only the current owner's done/req matter; other masters' done pulses are ignored.
   assign release_cond = bus.done[grant_id_r] | ~bus.req[grant_id_r];

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [CNT_W-1:0] count, count_next;

   assign wd_expire = (state == S_OWNED) && (count == CNT_LAST);

   // Hold counter: cleared on each new grant, saturating while owned.
   always_comb begin
      count_next = count;
      if (state == S_IDLE && any_req) begin
         count_next = '0;
      end else if (state == S_OWNED && count != CNT_MAX) begin
         count_next = count + CNT_W'(1);
      end
   end

   // Hold counter register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end
`else
   assign wd_expire = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: a release always passes through one RELEASE cycle before arbitrating again.
   always_comb begin
      state_next = S_IDLE;
      case (state)
         S_IDLE:    state_next = any_req ? S_OWNED : S_IDLE;
         S_OWNED:   state_next = (release_cond || wd_expire) ? S_RELEASE : S_OWNED;
         S_RELEASE: state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and the round-robin pointer.
   always_comb begin
      grant_next    = grant_r;
      grant_id_next = grant_id_r;
      rr_ptr_next   = rr_ptr;
      timeout_next  = 1'b0;
      case (state)
         S_IDLE: begin
            grant_next = '0;
            if (any_req) begin
               grant_next[winner] = 1'b1;
               grant_id_next      = winner;
               rr_ptr_next        = (int'(winner) == NUM_MASTERS - 1) ? '0 : winner + ID_W'(1);
            end
         end
         S_OWNED: begin
            if (release_cond) begin
               grant_next = '0;
            end else if (wd_expire) begin
               grant_next   = '0;
               timeout_next = 1'b1;
            end
         end
         default: grant_next = '0;
      endcase
   end

   // Output and pointer registers; grant_id keeps the last owner while the bus is free.
   always_ff @(posedge clk) begin
      if (!reset) begin
         grant_r    <= '0;
         grant_id_r <= '0;
         rr_ptr     <= '0;
         timeout_r  <= 1'b0;
      end else begin
         grant_r    <= grant_next;
         grant_id_r <= grant_id_next;
         rr_ptr     <= rr_ptr_next;
         timeout_r  <= timeout_next;
      end
   end

   assign bus.grant    = grant_r;
   assign bus.grant_id = grant_id_r;
   assign bus.bus_busy = |grant_r;
   assign bus.timeout  = timeout_r;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Arbitrates the shared serial system bus between up to NUM_MASTERS master ports.
- Each master port raises a request, receives a one-hot grant, and holds the bus until its transaction completes.
- Sits between the master port blocks and the bus address/data muxes: grant_id drives the mux select, grant[i] enables master i's port.
- Round-robin fairness, with one idle turnaround cycle between owners.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- TIMEOUT_CYC, 1024, cycles a grant may be held without a done pulse before it is revoked (only used with ARB_TIMEOUT_EN).
- CNT_W, 16, width of the hold/timeout counter; TIMEOUT_CYC must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- req  in  NUM_MASTERS  level request per master; held high until its transaction ends.
- done  in  NUM_MASTERS  one-cycle completion pulse per master (master's tx_done/rx_done for the final beat).
- grant  out  NUM_MASTERS  one-hot grant, registered; all-zero when the bus is free.
- grant_id  out  ID_W  binary index of current owner; ID_W = max(1, clog2(NUM_MASTERS)); holds last owner when idle.
- bus_busy  out  1  high while any grant is asserted.
- timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, grant=0, grant_id=0, bus_busy=0, timeout=0, rr_ptr=0, count=0. Takes effect even mid-transaction: grant drops at that edge.
- States: IDLE, OWNED, RELEASE.
- IDLE:
  - If any req bit is high: select the first requester searching from rr_ptr upward, wrapping modulo NUM_MASTERS.
  - Next edge: grant[w]=1, grant_id=w, bus_busy=1, rr_ptr=(w+1) mod NUM_MASTERS, count=0, go OWNED.
  - Latency from req rising to grant is 1 cycle.
- OWNED:
  - count increments each cycle and saturates at 2^CNT_W-1.
  - If done[grant_id]==1 OR req[grant_id]==0: next edge grant=0, bus_busy=0, go RELEASE.
  - Both events in the same cycle cause a single release.
- RELEASE:
  - Exactly one cycle, grant=0; then go IDLE.
  - Requests present during RELEASE are arbitrated in IDLE on the following cycle, so the minimum gap between grants is 2 idle-grant cycles.
- Ignored inputs:
  - done pulses from non-owning masters are ignored in all states.
  - done while IDLE/RELEASE is ignored.
- Fairness: after owner w releases, w has the lowest priority. With all masters requesting continuously, grants rotate 0,1,...,N-1,0.
- Invariants: grant is always one-hot or zero, and never changes owner without passing through RELEASE.
- Unused states decode to IDLE with grant=0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - In OWNED, when count reaches TIMEOUT_CYC-1 with no release condition, the next edge drops grant, pulses timeout=1 for one cycle, and goes RELEASE.
  - A release condition in that same cycle takes precedence: normal release, no timeout pulse.
  - rr_ptr advances as normal, so the stalled master loses priority.
- Not defined: no watchdog; count logic may be removed; timeout tied 0; a grant is held indefinitely until done or req drop.

Decomposition:
- Shared bus package: state encoding constants (IDLE=0, OWNED=1, RELEASE=2), the default NUM_MASTERS, and the ID_W derivation function.
- One sub-module is natural: rr_picker, combinational. Inputs req and rr_ptr; outputs winner index and any_req. It is reused by the slave-side arbiter.

Test Plan:
- Reset low 3 cycles while req=2'b11, then release reset:
  - outputs stay 0 during reset;
  - the cycle after reset goes high, grant=2'b01, grant_id=0.
- req=2'b11 held, done pulses 6 cycles after each grant:
  - grant sequence 01,10,01,10;
  - exactly one zero-grant RELEASE cycle plus one IDLE cycle between owners.
- Master 1 owns, master 0 pulses done:
  - ignored, grant stays 2'b10;
  - master 1 drops req, so grant=0 next edge.
- done[0] and req[0] fall in the same cycle while master 0 owns:
  - single release, no double-advance of rr_ptr;
  - next grant goes to master 1 if requesting.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=8, master 0 holds req with no done:
  - grant drops 8 cycles after assertion, timeout pulses once;
  - master 1 (requesting) granted 2 cycles later.
- Reset driven low while OWNED mid-transfer: grant=0 and bus_busy=0 at that edge; state is IDLE afterwards.
